// File: rtl/rs_simple_if.sv
// Bundle between the dispatcher, the CDB, the simple FU and the rs_simple reservation station.
// The master drives dispatch, CDB and issue. The slave is the station, which returns its entries.
interface rs_simple_if #(
  parameter int ENTRY_W = 114,
  parameter int TAG_W   = 4
);
  logic               dispatch_0_valid;
  logic [ENTRY_W-1:0] dispatch_0_inst;
  logic [TAG_W-1:0]   dispatch_0_rob;
  logic               dispatch_1_valid;
  logic [ENTRY_W-1:0] dispatch_1_inst;
  logic [TAG_W-1:0]   dispatch_1_rob;
  logic               cdb_0_valid;
  logic [TAG_W-1:0]   cdb_0_tag;
  logic [31:0]        cdb_0_data;
  logic               cdb_1_valid;
  logic [TAG_W-1:0]   cdb_1_tag;
  logic [31:0]        cdb_1_data;
  logic               simple_0_issue;
  logic               simple_1_issue;
  logic [ENTRY_W-1:0] rs_simple_0;
  logic [ENTRY_W-1:0] rs_simple_1;
  logic [TAG_W-1:0]   rs_simple_0_entry_num;
  logic [TAG_W-1:0]   rs_simple_1_entry_num;
  logic               selector;
  logic [1:0]         rs_simple_free;

  modport master (
    output dispatch_0_valid, dispatch_0_inst, dispatch_0_rob,
    output dispatch_1_valid, dispatch_1_inst, dispatch_1_rob,
    output cdb_0_valid, cdb_0_tag, cdb_0_data,
    output cdb_1_valid, cdb_1_tag, cdb_1_data,
    output simple_0_issue, simple_1_issue,
    input  rs_simple_0, rs_simple_1, rs_simple_0_entry_num, rs_simple_1_entry_num,
    input  selector, rs_simple_free
  );

  modport slave (
    input  dispatch_0_valid, dispatch_0_inst, dispatch_0_rob,
    input  dispatch_1_valid, dispatch_1_inst, dispatch_1_rob,
    input  cdb_0_valid, cdb_0_tag, cdb_0_data,
    input  cdb_1_valid, cdb_1_tag, cdb_1_data,
    input  simple_0_issue, simple_1_issue,
    output rs_simple_0, rs_simple_1, rs_simple_0_entry_num, rs_simple_1_entry_num,
    output selector, rs_simple_free
  );
endinterface

// File: rtl/rs_simple.sv
// Two-entry reservation station for the simple integer FU.
// It wakes operands from two CDBs, including a bypass at dispatch, and tracks the newer entry with selector.
module rs_simple #(
  parameter int ENTRY_W = 114,
  parameter int TAG_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  rs_simple_if.slave  bus
);
  logic [1:0]         occ_reg, occ_next;
  logic [ENTRY_W-1:0] entry_reg [2];
  logic [ENTRY_W-1:0] entry_next [2];
  logic [TAG_W-1:0]   rob_reg [2];
  logic [TAG_W-1:0]   rob_next [2];
  logic               selector_reg, selector_next;

  logic [ENTRY_W-1:0] stored_woken [2];
  logic [ENTRY_W-1:0] incoming [2];
  logic [1:0]         issue;
  logic               first_valid;
  logic [ENTRY_W-1:0] first_inst;
  logic [TAG_W-1:0]   first_rob;

  // A pending operand keeps its producer tag in its low bits. cdb_0 is checked first, so it wins a double match.
  function automatic logic [ENTRY_W-1:0] wake_up(
    input logic [ENTRY_W-1:0] e,
    input logic v0, input logic [TAG_W-1:0] t0, input logic [31:0] d0,
    input logic v1, input logic [TAG_W-1:0] t1, input logic [31:0] d1
  );
    logic [ENTRY_W-1:0] r;
    r = e;
    if (!e[5]) begin
      if (v0 && t0 == e[6 +: TAG_W]) begin
        r[37:6] = d0;
        r[5]    = 1'b1;
      end else if (v1 && t1 == e[6 +: TAG_W]) begin
        r[37:6] = d1;
        r[5]    = 1'b1;
      end
    end
    if (!e[38]) begin
      if (v0 && t0 == e[39 +: TAG_W]) begin
        r[70:39] = d0;
        r[38]    = 1'b1;
      end else if (v1 && t1 == e[39 +: TAG_W]) begin
        r[70:39] = d1;
        r[38]    = 1'b1;
      end
    end
    return r;
  endfunction

  assign issue = {bus.simple_1_issue, bus.simple_0_issue};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_wake
      assign stored_woken[gi] = wake_up(entry_reg[gi],
                                        bus.cdb_0_valid, bus.cdb_0_tag, bus.cdb_0_data,
                                        bus.cdb_1_valid, bus.cdb_1_tag, bus.cdb_1_data);
    end
  endgenerate

  assign incoming[0] = wake_up(bus.dispatch_0_inst,
                               bus.cdb_0_valid, bus.cdb_0_tag, bus.cdb_0_data,
                               bus.cdb_1_valid, bus.cdb_1_tag, bus.cdb_1_data);
  assign incoming[1] = wake_up(bus.dispatch_1_inst,
                               bus.cdb_0_valid, bus.cdb_0_tag, bus.cdb_0_data,
                               bus.cdb_1_valid, bus.cdb_1_tag, bus.cdb_1_data);

  always_comb begin
    occ_next      = occ_reg;
    selector_next = selector_reg;
    first_valid   = bus.dispatch_0_valid | bus.dispatch_1_valid;
    first_inst    = bus.dispatch_0_valid ? incoming[0] : incoming[1];
    first_rob     = bus.dispatch_0_valid ? bus.dispatch_0_rob : bus.dispatch_1_rob;
    for (int i = 0; i < 2; i++) begin
      entry_next[i] = occ_reg[i] ? stored_woken[i] : entry_reg[i];
      rob_next[i]   = rob_reg[i];
      if (occ_reg[i] && issue[i]) begin
        occ_next[i]   = 1'b0;
        entry_next[i] = '0;
      end
    end
    // Allocation uses only the free slots seen at this edge. Entries freed by issue become reusable next cycle.
    case (occ_reg)
      2'b00: begin
        if (bus.dispatch_0_valid && bus.dispatch_1_valid) begin
          occ_next      = 2'b11;
          entry_next[0] = incoming[0];
          rob_next[0]   = bus.dispatch_0_rob;
          entry_next[1] = incoming[1];
          rob_next[1]   = bus.dispatch_1_rob;
          selector_next = 1'b1;
        end else if (first_valid) begin
          occ_next[0]   = 1'b1;
          entry_next[0] = first_inst;
          rob_next[0]   = first_rob;
        end
      end
      2'b01: begin
        if (first_valid) begin
          occ_next[1]   = 1'b1;
          entry_next[1] = first_inst;
          rob_next[1]   = first_rob;
          if (occ_next[0]) selector_next = 1'b1;
        end
      end
      2'b10: begin
        if (first_valid) begin
          occ_next[0]   = 1'b1;
          entry_next[0] = first_inst;
          rob_next[0]   = first_rob;
          if (occ_next[1]) selector_next = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_reg      <= '0;
      selector_reg <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        entry_reg[i] <= '0;
        rob_reg[i]   <= '0;
      end
    end else begin
      occ_reg      <= occ_next;
      selector_reg <= selector_next;
      for (int i = 0; i < 2; i++) begin
        entry_reg[i] <= entry_next[i];
        rob_reg[i]   <= rob_next[i];
      end
    end
  end

  assign bus.rs_simple_0           = occ_reg[0] ? entry_reg[0] : '0;
  assign bus.rs_simple_1           = occ_reg[1] ? entry_reg[1] : '0;
  assign bus.rs_simple_0_entry_num = rob_reg[0];
  assign bus.rs_simple_1_entry_num = rob_reg[1];
  assign bus.selector              = selector_reg;
  assign bus.rs_simple_free        = {1'b0, ~occ_reg[0]} + {1'b0, ~occ_reg[1]};
endmodule

// File: tb/tb_rs_simple.sv
// Self-checking bench for rs_simple: directed scenarios followed by random traffic.
// The reference model is written at the level of operand fields.
module tb_rs_simple;
  typedef struct packed {
    logic [31:0] resv;
    logic [5:0]  aluop;
    logic [4:0]  ctrl;
    logic [31:0] s2;
    logic        s2v;
    logic [31:0] s1;
    logic        s1v;
    logic [4:0]  rd;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rs_simple_if bus ();
  rs_simple dut (.clk(clk), .rst(rst), .bus(bus));

  // stimulus
  logic [1:0]  d_v, cdb_v, iss;
  ent_t        d_ent [2];
  logic [3:0]  d_rob [2];
  logic [3:0]  cdb_t [2];
  logic [31:0] cdb_d [2];

  // reference model
  ent_t       m [2];
  logic [1:0] m_occ;
  logic [3:0] m_rob [2];
  logic       m_sel;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic ent_t rand_ent();
    ent_t e;
    e.resv  = $urandom;
    e.aluop = 6'($urandom);
    e.ctrl  = 5'($urandom);
    e.s2    = $urandom;
    e.s2v   = 1'($urandom_range(0, 1));
    e.s1    = $urandom;
    e.s1v   = 1'($urandom_range(0, 1));
    e.rd    = 5'($urandom);
    return e;
  endfunction

  function automatic ent_t mk(input logic [31:0] s1, input logic s1v, input logic [31:0] s2, input logic s2v);
    ent_t e;
    e     = rand_ent();
    e.s1  = s1;
    e.s1v = s1v;
    e.s2  = s2;
    e.s2v = s2v;
    return e;
  endfunction

  // Returns {valid, value}. A pending operand is resolved by the first matching broadcast.
  function automatic logic [32:0] wake_op(input logic [31:0] val, input logic vld);
    if (vld) return {1'b1, val};
    for (int k = 0; k < 2; k++)
      if (cdb_v[k] && cdb_t[k] == val[3:0]) return {1'b1, cdb_d[k]};
    return {1'b0, val};
  endfunction

  function automatic ent_t wake_ent(input ent_t e);
    ent_t r;
    r = e;
    {r.s1v, r.s1} = wake_op(e.s1, e.s1v);
    {r.s2v, r.s2} = wake_op(e.s2, e.s2v);
    return r;
  endfunction

  task automatic model_step();
    ent_t       nm [2];
    logic [1:0] no;
    int         free_idx[$];
    ent_t       inc[$];
    logic [3:0] inc_rob[$];
    int         n;
    if (rst) begin
      m_occ = '0;
      m_sel = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m[i]     = '0;
        m_rob[i] = '0;
      end
      return;
    end
    no = m_occ;
    for (int i = 0; i < 2; i++) begin
      nm[i] = m[i];
      if (m_occ[i]) begin
        if (iss[i]) begin
          nm[i] = '0;
          no[i] = 1'b0;
        end else begin
          nm[i] = wake_ent(m[i]);
        end
      end
      if (!m_occ[i]) free_idx.push_back(i);
    end
    for (int s = 0; s < 2; s++)
      if (d_v[s]) begin
        inc.push_back(wake_ent(d_ent[s]));
        inc_rob.push_back(d_rob[s]);
      end
    n = (free_idx.size() < inc.size()) ? free_idx.size() : inc.size();
    for (int k = 0; k < n; k++) begin
      nm[free_idx[k]]    = inc[k];
      no[free_idx[k]]    = 1'b1;
      m_rob[free_idx[k]] = inc_rob[k];
    end
    if (n == 2) m_sel = 1'(free_idx[1]);
    else if (n == 1 && no[1 - free_idx[0]]) m_sel = 1'(free_idx[0]);
    m     = nm;
    m_occ = no;
  endtask

  task automatic idle();
    rst   = 1'b0;
    d_v   = '0;
    cdb_v = '0;
    iss   = '0;
    for (int i = 0; i < 2; i++) begin
      d_ent[i] = rand_ent();
      d_rob[i] = 4'($urandom);
      cdb_t[i] = 4'($urandom);
      cdb_d[i] = $urandom;
    end
  endtask

  task automatic apply();
    bus.dispatch_0_valid = d_v[0];
    bus.dispatch_0_inst  = d_ent[0];
    bus.dispatch_0_rob   = d_rob[0];
    bus.dispatch_1_valid = d_v[1];
    bus.dispatch_1_inst  = d_ent[1];
    bus.dispatch_1_rob   = d_rob[1];
    bus.cdb_0_valid      = cdb_v[0];
    bus.cdb_0_tag        = cdb_t[0];
    bus.cdb_0_data       = cdb_d[0];
    bus.cdb_1_valid      = cdb_v[1];
    bus.cdb_1_tag        = cdb_t[1];
    bus.cdb_1_data       = cdb_d[1];
    bus.simple_0_issue   = iss[0];
    bus.simple_1_issue   = iss[1];
  endtask

  task automatic step();
    apply();
    @(posedge clk);
    #1;
    cyc++;
    model_step();
    check_eq("entry0", 128'(bus.rs_simple_0), 128'(m_occ[0] ? m[0] : ent_t'('0)));
    check_eq("entry1", 128'(bus.rs_simple_1), 128'(m_occ[1] ? m[1] : ent_t'('0)));
    if (m_occ[0] || rst) check_eq("rob0", 128'(bus.rs_simple_0_entry_num), 128'(m_rob[0]));
    if (m_occ[1] || rst) check_eq("rob1", 128'(bus.rs_simple_1_entry_num), 128'(m_rob[1]));
    check_eq("selector", 128'(bus.selector), 128'(m_sel));
    check_eq("free", 128'(bus.rs_simple_free), 128'(2 - m_occ[0] - m_occ[1]));
    $display("cyc %0d rst=%0b disp=%b cdb=%b iss=%b occ=%b sel=%0b free=%0d",
             cyc, rst, d_v, cdb_v, iss, m_occ, bus.selector, bus.rs_simple_free);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step();
    step();
    check_eq("reset free", 128'(bus.rs_simple_free), 128'(2));
    check_eq("reset entry0", 128'(bus.rs_simple_0), 128'(0));

    // single ready dispatch
    idle();
    d_v[0] = 1'b1; d_ent[0] = mk(32'd5, 1'b1, 32'd7, 1'b1); d_rob[0] = 4'd3;
    step();
    check_eq("tp1 s1", 128'(bus.rs_simple_0[37:6]), 128'(5));
    check_eq("tp1 s2", 128'(bus.rs_simple_0[70:39]), 128'(7));
    check_eq("tp1 rob", 128'(bus.rs_simple_0_entry_num), 128'(3));
    check_eq("tp1 free", 128'(bus.rs_simple_free), 128'(1));
    check_eq("tp1 entry1", 128'(bus.rs_simple_1), 128'(0));
    idle(); iss[0] = 1'b1;
    step();

    // dual dispatch, then dispatch while full
    idle();
    d_v = 2'b11;
    d_ent[0] = mk($urandom, 1'b1, 32'hABCD0006, 1'b0); d_rob[0] = 4'd2;
    d_ent[1] = mk(32'h1234500B, 1'b0, $urandom, 1'b1); d_rob[1] = 4'd9;
    step();
    check_eq("tp2 sel", 128'(bus.selector), 128'(1));
    check_eq("tp2 free", 128'(bus.rs_simple_free), 128'(0));
    check_eq("tp2 rob1", 128'(bus.rs_simple_1_entry_num), 128'(9));
    idle(); d_v[0] = 1'b1; d_rob[0] = 4'd15;
    step();
    check_eq("tp2 full rob0", 128'(bus.rs_simple_0_entry_num), 128'(2));

    // wakeup via cdb_1
    idle(); cdb_v[1] = 1'b1; cdb_t[1] = 4'd6; cdb_d[1] = 32'hDEADBEEF;
    step();
    check_eq("tp3 s2", 128'(bus.rs_simple_0[70:39]), 128'(32'hDEADBEEF));
    check_eq("tp3 s2v", 128'(bus.rs_simple_0[38]), 128'(1));

    // issue and dispatch in the same cycle: dispatch dropped
    idle(); iss[0] = 1'b1; d_v[0] = 1'b1;
    step();
    check_eq("tp5 free", 128'(bus.rs_simple_free), 128'(1));
    check_eq("tp5 entry0", 128'(bus.rs_simple_0), 128'(0));
    idle(); d_v[0] = 1'b1; d_ent[0] = mk(32'd1, 1'b1, 32'hFFFF0006, 1'b0); d_rob[0] = 4'd5;
    step();
    check_eq("tp5 sel", 128'(bus.selector), 128'(0));
    check_eq("tp5 rob0", 128'(bus.rs_simple_0_entry_num), 128'(5));

    // both buses hit the same tag: cdb_0 wins
    idle(); cdb_v = 2'b11; cdb_t[0] = 4'd6; cdb_t[1] = 4'd6; cdb_d[0] = 32'd1; cdb_d[1] = 32'd2;
    step();
    check_eq("tp3 prio", 128'(bus.rs_simple_0[70:39]), 128'(1));

    // dispatch bypass
    idle(); iss[1] = 1'b1;
    step();
    idle(); d_v[0] = 1'b1; d_ent[0] = mk(32'h00000004, 1'b0, 32'd3, 1'b1); d_rob[0] = 4'd7;
    cdb_v[0] = 1'b1; cdb_t[0] = 4'd4; cdb_d[0] = 32'h10;
    step();
    check_eq("tp4 s1", 128'(bus.rs_simple_1[37:6]), 128'(32'h10));
    check_eq("tp4 s1v", 128'(bus.rs_simple_1[5]), 128'(1));

    // reset while full with a CDB hit
    idle(); cdb_v[0] = 1'b1; cdb_t[0] = 4'd6; rst = 1'b1;
    step();
    check_eq("tp6 free", 128'(bus.rs_simple_free), 128'(2));
    check_eq("tp6 entry1", 128'(bus.rs_simple_1), 128'(0));

    // random traffic
    for (int t = 0; t < 600; t++) begin
      idle();
      rst   = ($urandom_range(0, 63) == 0);
      d_v   = 2'($urandom);
      cdb_v = 2'($urandom);
      iss   = 2'($urandom_range(0, 3) == 0 ? $urandom : 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/rs_simple.md
Name: rs_simple

Overview:
- 2-entry reservation station feeding the "simple" integer FU (ex_simple).
- Accepts up to 2 dispatched instructions per cycle and holds them until both source operands are valid.
- Captures operand values from two result-broadcast buses (CDB) by ROB tag.
- Presents both entries, their ROB numbers and an age selector to the FU, and frees an entry when the FU signals issue.

Parameters:
- ENTRY_W, 114, width of one RS entry
- TAG_W, 4, ROB tag width (16-entry ROB)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous reset, active-high
- dispatch_0_valid  input  1  dispatch slot 0 carries an instruction (older of the two slots)
- dispatch_0_inst  input  114  entry in standard format
- dispatch_0_rob  input  4  ROB number of slot 0
- dispatch_1_valid  input  1  dispatch slot 1 valid (younger)
- dispatch_1_inst  input  114  entry, slot 1
- dispatch_1_rob  input  4  ROB number of slot 1
- cdb_0_valid  input  1  broadcast 0 valid
- cdb_0_tag  input  4  ROB number of produced result
- cdb_0_data  input  32  result value
- cdb_1_valid / cdb_1_tag / cdb_1_data  input  1/4/32  broadcast 1
- simple_0_issue  input  1  FU consumed entry 0 this cycle
- simple_1_issue  input  1  FU consumed entry 1 this cycle
- rs_simple_0  output  114  entry 0 contents; all zero when empty
- rs_simple_1  output  114  entry 1 contents; all zero when empty
- rs_simple_0_entry_num  output  4  ROB number of entry 0
- rs_simple_1_entry_num  output  4  ROB number of entry 1
- selector  output  1  index of the newer occupied entry
- rs_simple_free  output  2  free entries (0..2), for dispatch

Behaviour:
- Entry format, 114 bits:
  - [113:82] reserved, stored unchanged
  - [81:76] aluop
  - [75] memwrite, [74] memread, [73] memtoreg, [72] branch, [71] regwrite
  - [70:39] s2, [38] s2_valid
  - [37:6] s1, [5] s1_valid
  - [4:0] rd
- Pending operands: when sX_valid=0, sX[3:0] holds the ROB tag of the producer; the upper bits are don't-care.
- Internal state: occ[1:0] (occupied bits), two entry registers, two 4-bit ROB registers, selector.
- Outputs: all outputs are registered state. rs_simple_N is driven to 114'b0 when occ[N]=0, so an empty entry never appears ready.
- rs_simple_free = number of zero bits in occ. It reflects the current state and does not count frees happening in the same cycle.
- Reset (rst=1 at an edge):
  - occ=0, all entry and ROB registers 0, selector=0.
  - Therefore all outputs are 0 and rs_simple_free=2.
  - Reset overrides dispatch, issue and CDB in the same cycle; in-flight entries are discarded.
- Allocation, evaluated at each edge:
  - The lowest free index receives the oldest valid dispatch slot.
  - One free entry and both slots valid: slot 0 is accepted, slot 1 is dropped.
  - No free entry: all dispatch is ignored.
  - The dispatcher must not exceed rs_simple_free.
  - An entry freed by issue in the same cycle is not reusable until the next cycle.
- Selector update:
  - One entry allocated while the other stays occupied: selector <= allocated index.
  - Both entries allocated in the same cycle: selector <= index holding slot 1.
  - Otherwise selector holds its value.
- Wakeup: for every occupied entry with sX_valid=0, if cdb_k_valid and cdb_k_tag==sX[3:0], then sX <= cdb_k_data and sX_valid <= 1 at the edge.
  - Both buses matching the same operand: cdb_0 wins.
  - s1 and s2 are woken independently; both may wake in one cycle.
- Dispatch bypass: the same CDB comparison is applied to an incoming instruction's pending operands before it is written. A result broadcast in the dispatch cycle is therefore never missed.
- Issue:
  - simple_N_issue=1 with occ[N]=1: occ[N] <= 0 and the entry register is cleared.
  - Issue of an empty entry is ignored.
  - Issue takes priority over wakeup on the same entry.
- Latency:
  - Dispatch to visible on outputs: 1 cycle.
  - CDB to operand valid: 1 cycle.
  - Issue to entry empty: 1 cycle.
- Entries never shift. Ages are tracked only by selector.

Test Plan:
- Reset, then dispatch slot 0 with s1_valid=s2_valid=1, s1=5, s2=7, rob=3. Next cycle: rs_simple_0[37:6]=5, rs_simple_0[70:39]=7, entry_num_0=3, rs_simple_free=1, rs_simple_1=0.
- Dispatch slot 0 (rob=2) and slot 1 (rob=9) together, both with one pending source. Next cycle: entry 0 holds rob 2, entry 1 holds rob 9, selector=1, rs_simple_free=0. A third dispatch while full leaves state unchanged.
- Entry 0 has s2 pending on tag 6. Drive cdb_1_valid, tag 6, data 0xDEADBEEF. Next cycle: s2=0xDEADBEEF, s2_valid=1. Repeat with cdb_0 (data 1) and cdb_1 (data 2) on the same tag: s2=1.
- Dispatch an instruction with s1 pending on tag 4 in the same cycle as cdb_0 tag 4, data 0x10. Next cycle: s1=0x10, s1_valid=1.
- Both entries full. Assert simple_0_issue and dispatch a new instruction in the same cycle: the dispatch is ignored and occ=10b. Next cycle's dispatch lands in entry 0 and selector=0.
- Assert rst while both entries are occupied and a CDB hit is present. Next cycle: all outputs 0, rs_simple_free=2.
